fp_argmax: RTL and testbench



---
 rtl/mlp_pkg.sv | 17 +
 rtl/fp32_order_key.sv | 14 +
 rtl/fp_argmax.sv | 119 +++++++++++
 tb/tb_fp_argmax.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// rtl/mlp_pkg.sv - shared types and constants for the classifier back end
package mlp_pkg;

    localparam int DEFAULT_NUM_CLASSES = 10;
    localparam int DEFAULT_INDEX_BITS  = 4;

    typedef logic [31:0] fp32_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } argmax_state_t;

    localparam fp32_t FP32_QNAN = 32'h7FC0_0000;

endpackage

// File: rtl/fp32_order_key.sv
// rtl/fp32_order_key.sv - maps fp32 bits to an unsigned key with numeric ordering
module fp32_order_key
    import mlp_pkg::*;
(
    input  fp32_t       x,
    output logic [31:0] key,
    output logic        is_nan
);

    // Negative values flip entirely so larger magnitude sorts lower; positives just move above all negatives.
    assign key    = x[31] ? ~x : (x ^ 32'h8000_0000);
    assign is_nan = (&x[30:23]) && (|x[22:0]);

endmodule

// File: rtl/fp_argmax.sv
// rtl/fp_argmax.sv - streaming arg-max over one image's fp32 class scores
module fp_argmax
    import mlp_pkg::*;
#(
    parameter int NUM_CLASSES = DEFAULT_NUM_CLASSES,
    parameter int INDEX_BITS  = DEFAULT_INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  in_valid,
    input  logic [31:0]           in_data,
    output logic                  in_ready,
    output logic                  busy,
    output logic                  done,
    output logic [INDEX_BITS-1:0] index_pred,
    output logic [31:0]           max_value,
    output logic                  nan_seen,
    output logic                  overrun
);

    localparam int CNT_W = $clog2(NUM_CLASSES);

    argmax_state_t         r_state;
    logic [CNT_W-1:0]      r_count;
    logic [31:0]           r_best_key;
    logic [INDEX_BITS-1:0] r_best_idx;
    fp32_t                 r_best_val;
    logic                  r_any_valid;
    logic                  r_done;
    logic [INDEX_BITS-1:0] r_index_pred;
    fp32_t                 r_max_value;
    logic                  r_nan_seen;
    logic                  r_overrun;

    logic [31:0]           w_key;
    logic                  w_is_nan;
    logic                  w_accept;
    logic                  w_take;
    logic                  w_last;
    logic                  w_any_next;
    logic [INDEX_BITS-1:0] w_idx_next;
    fp32_t                 w_val_next;

    fp32_order_key u_key (
        .x      (in_data),
        .key    (w_key),
        .is_nan (w_is_nan)
    );

    assign w_accept = in_valid && (r_state == ACCUM);
    // Strictly greater keeps the earliest index on ties; NaN never competes.
    assign w_take   = !w_is_nan && (!r_any_valid || (w_key > r_best_key));
    assign w_last   = (r_count == CNT_W'(NUM_CLASSES - 1));

    // Best after folding in the current beat, so the final beat counts toward the result.
    assign w_any_next = r_any_valid || w_take;
    assign w_idx_next = w_take ? INDEX_BITS'(r_count) : r_best_idx;
    assign w_val_next = w_take ? in_data : r_best_val;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_count      <= '0;
            r_best_key   <= '0;
            r_best_idx   <= '0;
            r_best_val   <= '0;
            r_any_valid  <= 1'b0;
            r_done       <= 1'b0;
            r_index_pred <= '0;
            r_max_value  <= '0;
            r_nan_seen   <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (start) begin
                r_state     <= ACCUM;
                r_count     <= '0;
                r_best_key  <= '0;
                r_best_idx  <= '0;
                r_best_val  <= '0;
                r_any_valid <= 1'b0;
                r_nan_seen  <= 1'b0;
                r_overrun   <= 1'b0;
            end else begin
                if (in_valid && (r_state != ACCUM)) begin
                    r_overrun <= 1'b1;
                end
                if (w_accept) begin
                    r_count <= r_count + CNT_W'(1);
                    if (w_is_nan) begin
                        r_nan_seen <= 1'b1;
                    end
                    if (w_take) begin
                        r_best_key  <= w_key;
                        r_best_idx  <= w_idx_next;
                        r_best_val  <= in_data;
                        r_any_valid <= 1'b1;
                    end
                    if (w_last) begin
                        r_state      <= DONE;
                        r_done       <= 1'b1;
                        r_index_pred <= w_any_next ? w_idx_next : '0;
                        r_max_value  <= w_any_next ? w_val_next : FP32_QNAN;
                    end
                end
            end
        end
    end

    assign in_ready   = (r_state == ACCUM);
    assign busy       = (r_state == ACCUM);
    assign done       = r_done;
    assign index_pred = r_index_pred;
    assign max_value  = r_max_value;
    assign nan_seen   = r_nan_seen;
    assign overrun    = r_overrun;

endmodule

// File: tb/tb_fp_argmax.sv
// tb/tb_fp_argmax.sv - directed table-driven bench for fp_argmax
module tb_fp_argmax;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        busy;
    logic        done;
    logic [3:0]  index_pred;
    logic [31:0] max_value;
    logic        nan_seen;
    logic        overrun;

    fp_argmax #(.NUM_CLASSES(10), .INDEX_BITS(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .busy       (busy),
        .done       (done),
        .index_pred (index_pred),
        .max_value  (max_value),
        .nan_seen   (nan_seen),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0][31:0] sc;
        logic [3:0]       idx;
        logic [31:0]      mx;
        logic             nan;
        logic             gap;
    } vec_t;

    localparam int NV = 7;
    vec_t             vecs [NV];
    logic [9:0][31:0] cur;
    int               n_tests = 0;
    int               n_fail  = 0;
    int               done_cnt = 0;
    int               d0;

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_image(input logic gap);
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 start = 1'b0;
        check("in_ready_after_start", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            if (gap) begin
                @(posedge clk); #1;
            end
            in_valid = 1'b1;
            in_data  = cur[i];
            @(posedge clk); #1 in_valid = 1'b0;
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] idx, input logic [31:0] mx, input logic nan);
        check({tag, "_done"}, done, 1);
        check({tag, "_idx"}, index_pred, idx);
        check({tag, "_max"}, max_value, mx);
        check({tag, "_nan"}, nan_seen, nan);
        @(posedge clk); #1;
        check({tag, "_done_low"}, done, 0);
        check({tag, "_busy_low"}, busy, 0);
        check({tag, "_idx_held"}, index_pred, idx);
    endtask

    initial begin
        for (int i = 0; i < 10; i++) begin
            vecs[1].sc[i] = 32'hBF80_0000;
            vecs[2].sc[i] = 32'hFF80_0000;
            vecs[3].sc[i] = 32'h7FC0_0001;
            vecs[4].sc[i] = 32'h3F80_0000;
            vecs[5].sc[i] = 32'hBF80_0000;
            vecs[6].sc[i] = 32'hFF80_0000;
        end
        vecs[0].sc = {32'h3F80_0000, 32'h3F66_6666, 32'h3F4C_CCCD, 32'h3F33_3333, 32'h3F19_999A,
                      32'h3F00_0000, 32'h3ECC_CCCD, 32'h3E99_999A, 32'h3E4C_CCCD, 32'h3DCC_CCCD};
        vecs[0].idx = 4'd9; vecs[0].mx = 32'h3F80_0000; vecs[0].nan = 1'b0; vecs[0].gap = 1'b0;
        vecs[1].sc[3] = 32'h40A0_0000; vecs[1].sc[7] = 32'h40A0_0000;
        vecs[1].idx = 4'd3; vecs[1].mx = 32'h40A0_0000; vecs[1].nan = 1'b0; vecs[1].gap = 1'b0;
        vecs[2].sc[0] = 32'h8000_0000; vecs[2].sc[1] = 32'h0000_0000;
        vecs[2].idx = 4'd1; vecs[2].mx = 32'h0000_0000; vecs[2].nan = 1'b0; vecs[2].gap = 1'b1;
        vecs[3].idx = 4'd0; vecs[3].mx = 32'h7FC0_0000; vecs[3].nan = 1'b1; vecs[3].gap = 1'b0;
        vecs[4].sc[4] = 32'h7F80_0000; vecs[4].sc[5] = 32'h7FC0_0001;
        vecs[4].idx = 4'd4; vecs[4].mx = 32'h7F80_0000; vecs[4].nan = 1'b1; vecs[4].gap = 1'b1;
        vecs[5].sc[0] = 32'hFFC0_0000; vecs[5].sc[6] = 32'hBF00_0000;
        vecs[5].idx = 4'd6; vecs[5].mx = 32'hBF00_0000; vecs[5].nan = 1'b1; vecs[5].gap = 1'b0;
        vecs[6].idx = 4'd0; vecs[6].mx = 32'hFF80_0000; vecs[6].nan = 1'b0; vecs[6].gap = 1'b0;

        reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_idx", index_pred, 0);
        check("rst_max", max_value, 0);
        check("rst_nan", nan_seen, 0);
        check("rst_overrun", overrun, 0);
        reset_n = 1'b1;

        for (int k = 0; k < NV; k++) begin
            cur = vecs[k].sc;
            d0  = done_cnt;
            send_image(vecs[k].gap);
            check($sformatf("v%0d_overrun", k), overrun, 0);
            check_result($sformatf("v%0d", k), vecs[k].idx, vecs[k].mx, vecs[k].nan);
            check($sformatf("v%0d_done_count", k), done_cnt - d0, 1);
        end

        // Abort after 4 beats of a large score, restart with gapped image whose max is class 2.
        d0 = done_cnt;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_data = 32'h4110_0000;
            @(posedge clk); #1 in_valid = 1'b0;
        end
        check("abort_busy", busy, 1);
        check("abort_idx_held", index_pred, vecs[NV-1].idx);
        check("abort_max_held", max_value, vecs[NV-1].mx);
        for (int i = 0; i < 10; i++) cur[i] = 32'h3F80_0000;
        cur[2] = 32'h4040_0000;
        send_image(1'b1);
        check_result("abort", 4'd2, 32'h4040_0000, 1'b0);
        check("abort_done_count", done_cnt - d0, 1);

        in_valid = 1'b1; in_data = 32'h7F80_0000;
        @(posedge clk); #1 in_valid = 1'b0;
        @(posedge clk); #1;
        check("ovr_set", overrun, 1);
        check("ovr_idx", index_pred, 2);
        check("ovr_max", max_value, 32'h4040_0000);
        check("ovr_done", done, 0);
        check("ovr_busy", busy, 0);

        start = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1 start = 1'b0; in_valid = 1'b0;
        check("start_ovr_clear", overrun, 0);
        check("start_ready", in_ready, 1);
        check("start_idx_kept", index_pred, 2);

        // Six beats including a NaN, then a one-cycle reset.
        d0 = done_cnt;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; in_data = (i == 1) ? 32'h7FC0_0001 : 32'h4000_0000;
            @(posedge clk); #1 in_valid = 1'b0;
        end
        check("pre_rst_nan", nan_seen, 1);
        reset_n = 1'b0;
        @(posedge clk); #1 reset_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_idx", index_pred, 0);
        check("mid_rst_max", max_value, 0);
        check("mid_rst_nan", nan_seen, 0);
        check("mid_rst_overrun", overrun, 0);
        repeat (15) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_cnt - d0, 0);
        check("mid_rst_idle", busy, 0);
        for (int i = 0; i < 10; i++) cur[i] = 32'hC000_0000;
        cur[8] = 32'h3F00_0000;
        send_image(1'b0);
        check_result("post_rst", 4'd8, 32'h3F00_0000, 1'b0);
        check("post_rst_done_count", done_cnt - d0, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
